// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors, line levels
// and the parity helper used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // data_xor is the XOR-reduction of the payload; odd parity inverts it.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..P-1 and strobes bit_end on the last count.
// Held at zero while restart is high so the first period is always full.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] P,
  output logic                      bit_end
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] cnt_d;

  assign bit_end = (cnt_q == (P - PRESCALE_WIDTH'(1)));

  always_comb begin
    cnt_d = cnt_q + PRESCALE_WIDTH'(1);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional
// parity, one or two stop bits; back-to-back frames with no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      DATA_ACK
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                    state_q, state_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]     sh_q, sh_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      stop2_q, stop2_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic                      accept;
  logic                      bit_end;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .CLK     (CLK),
    .RST     (RST),
    .restart (state_q == IDLE),
    .P       (p_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    sh_d       = sh_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    p_d        = p_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        accept = DATA_VALID;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d    = par_en_q ? PARITY : STOP;
            tx_d       = par_en_q ? par_bit_q : IDLE_LVL;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = IDLE_LVL;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (DATA_VALID) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LVL;
        busy_d  = 1'b0;
      end
    endcase

    // Accept overrides the per-state update; shared by IDLE and back-to-back.
    if (accept) begin
      state_d    = START;
      tx_d       = START_LVL;
      busy_d     = 1'b1;
      ack_d      = 1'b1;
      sh_d       = P_DATA;
      idx_d      = '0;
      stop_cnt_d = 1'b0;
      par_en_d   = PAR_EN;
      par_bit_d  = parity_bit(^P_DATA, PAR_TYP);
      stop2_d    = STOP2;
      p_d        = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_q       <= IDLE_LVL;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      sh_q       <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      p_q        <= PRESCALE_WIDTH'(1);
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      p_q        <= p_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign BUSY     = busy_q;
  assign DATA_ACK = ack_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: expected {TX_OUT,BUSY,DATA_ACK} per
// cycle is queued when a request is driven and compared cycle by cycle.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       dv = 1'b0;
  logic       sel = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       stop2 = 1'b0;
  logic [5:0] prescale = 6'd1;

  logic tx_a, busy_a, ack_a;
  logic tx_b, busy_b, ack_b;
  logic dv_a, dv_b;

  int n_vec = 0;
  int n_miss = 0;
  logic [2:0] exp_q[$];

  assign dv_a = dv & ~sel;
  assign dv_b = dv & sel;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut_a (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data), .DATA_VALID(dv_a),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
    .TX_OUT(tx_a), .BUSY(busy_a), .DATA_ACK(ack_a)
  );

  uart_tx_frame #(.DATA_WIDTH(7), .PRESCALE_WIDTH(6)) dut_b (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data[6:0]), .DATA_VALID(dv_b),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
    .TX_OUT(tx_b), .BUSY(busy_b), .DATA_ACK(ack_b)
  );

  function automatic void push_frame(input logic [7:0] data, input int dw, input logic pe,
                                     input logic pt, input logic s2, input logic [5:0] ps);
    int   p;
    logic bits[$];
    logic par;
    logic first;
    p = (ps == 6'd0) ? 1 : int'(ps);
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      par = par ^ data[i];
    end
    if (pe) bits.push_back(pt ? ~par : par);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    first = 1'b1;
    foreach (bits[i]) begin
      for (int j = 0; j < p; j++) begin
        exp_q.push_back({bits[i], 1'b1, first});
        first = 1'b0;
      end
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
  endfunction

  task automatic kick(input logic s, input logic [7:0] data, input int dw, input logic pe,
                      input logic pt, input logic s2, input logic [5:0] ps);
    @(negedge clk);
    sel = s; p_data = data; par_en = pe; par_typ = pt; stop2 = s2; prescale = ps;
    dv = 1'b1;
    push_frame(data, dw, pe, pt, s2, ps);
  endtask

  // Pops one expectation per cycle; optionally drops DATA_VALID, swaps the
  // payload or scrambles config mid-frame, and can stop early after max_k.
  task automatic drain(input string name, input int drop_at, input int swap_at,
                       input logic [7:0] swap_data, input bit scramble, input int max_k);
    int k;
    logic [2:0] e, obs;
    k = 0;
    while (exp_q.size() > 0 && k < max_k) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      obs = sel ? {tx_b, busy_b, ack_b} : {tx_a, busy_a, ack_a};
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL %s cycle %0d: tx/busy/ack got %b expected %b", name, k, obs, e);
      end else begin
        $display("%s cycle %0d: tx/busy/ack %b ok", name, k, obs);
      end
      if (k == drop_at) dv = 1'b0;
      if (k == swap_at) p_data = swap_data;
      if (scramble && k == 2) begin
        par_en = ~par_en; par_typ = ~par_typ; stop2 = ~stop2; prescale = prescale + 6'd3;
        p_data = ~p_data;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({tx_a, busy_a, ack_a} !== 3'b100 || {tx_b, busy_b, ack_b} !== 3'b100) begin
      n_miss++;
      $display("FAIL reset_state: a=%b b=%b expected 100", {tx_a, busy_a, ack_a}, {tx_b, busy_b, ack_b});
    end else $display("reset_state ok");
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    drain("reset_idle", 0, 0, 8'h00, 1'b0, 1000);
  endtask

  task automatic test_basic();
    kick(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 6'd1);
    push_idle(2);
    drain("basic_a5", 1, 0, 8'h00, 1'b1, 1000);
  endtask

  task automatic test_parity();
    kick(1'b0, 8'h01, 8, 1'b1, 1'b0, 1'b0, 6'd1);
    push_idle(1);
    drain("par_even_01", 1, 0, 8'h00, 1'b1, 1000);
    kick(1'b0, 8'h01, 8, 1'b1, 1'b1, 1'b0, 6'd1);
    push_idle(1);
    drain("par_odd_01", 1, 0, 8'h00, 1'b1, 1000);
    kick(1'b0, 8'hA5, 8, 1'b1, 1'b0, 1'b0, 6'd1);
    push_idle(1);
    drain("par_even_a5", 1, 0, 8'h00, 1'b0, 1000);
  endtask

  task automatic test_timing();
    kick(1'b0, 8'h3C, 8, 1'b1, 1'b0, 1'b1, 6'd4);
    push_idle(2);
    drain("p4_stop2_3c", 1, 0, 8'h00, 1'b1, 1000);
    kick(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 6'd0);
    push_idle(2);
    drain("p0_a5", 1, 0, 8'h00, 1'b0, 1000);
    kick(1'b0, 8'h96, 8, 1'b1, 1'b1, 1'b0, 6'd3);
    push_idle(2);
    drain("p3_odd_96", 1, 0, 8'h00, 1'b1, 1000);
  endtask

  task automatic test_back_to_back();
    kick(1'b0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 6'd1);
    push_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 6'd1);
    push_idle(2);
    drain("b2b_55_aa", 11, 1, 8'hAA, 1'b0, 1000);
  endtask

  task automatic test_reset_mid();
    kick(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 6'd2);
    drain("pre_reset", 1, 0, 8'h00, 1'b0, 9);
    exp_q.delete();
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tx_a, busy_a, ack_a} !== 3'b100) begin
      n_miss++;
      $display("FAIL async_reset: tx/busy/ack got %b expected 100", {tx_a, busy_a, ack_a});
    end else $display("async_reset ok");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dv = 1'b0;
    push_idle(4);
    drain("post_reset_idle", 0, 0, 8'h00, 1'b0, 1000);
    kick(1'b0, 8'hC3, 8, 1'b1, 1'b0, 1'b0, 6'd2);
    push_idle(2);
    drain("post_reset_c3", 1, 0, 8'h00, 1'b1, 1000);
  endtask

  task automatic test_width();
    kick(1'b1, 8'h41, 7, 1'b1, 1'b1, 1'b0, 6'd1);
    push_idle(2);
    drain("w7_odd_41", 1, 0, 8'h00, 1'b1, 1000);
    kick(1'b1, 8'h2B, 7, 1'b0, 1'b0, 1'b1, 6'd2);
    push_idle(2);
    drain("w7_stop2_2b", 1, 0, 8'h00, 1'b0, 1000);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_timing();
    test_back_to_back();
    test_reset_mid();
    test_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
